// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES ShiftRows pipeline: byte type, state-column
// count legality check and the per-row rotation offset function.
// Configuration macro (used by the modules importing this package):
//   AES_SHIFT_ROWS_INV_EN - when defined, InvShiftRows logic is built.
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [7:0] aes_byte_t;

   // The state matrix always has four rows regardless of the column count.
   localparam int unsigned NumRows = 4;

   // Rijndael permits 4, 6 or 8 state columns.
   function automatic bit nb_legal(input int unsigned nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Rotation offset C[r]: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8.
   function automatic int unsigned row_offset(input int unsigned nb, input int unsigned r);
      if ((nb == 8) && (r >= 2)) begin
         return r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_row_rotate.sv
// -----------------------------------------------------------------------------
// aes_row_rotate
// Byte rotation of one state row. Byte 0 is the MSB byte of the row.
// Forward: rotate left by OFFSET (byte 0 takes byte OFFSET).
// Inverse: rotate right by OFFSET (only built with AES_SHIFT_ROWS_INV_EN).
// Ports:
//   row_i  - input row, 8*NB bits
//   inv_i  - 1 selects the inverse rotation
//   row_o  - rotated row, 8*NB bits
// -----------------------------------------------------------------------------
module aes_row_rotate
   import aes_pkg::*;
#(
   parameter int unsigned NB     = 4,
   parameter int unsigned OFFSET = 0
) (
   input  logic [8*NB-1:0] row_i,
   input  logic            inv_i,
   output logic [8*NB-1:0] row_o
);

   for (genvar c = 0; c < NB; c++) begin : g_byte
      localparam int unsigned FwdSrc = (c + OFFSET) % NB;
      aes_byte_t fwd_b;

      assign fwd_b = row_i[8*NB-1-8*FwdSrc -: 8];

`ifdef AES_SHIFT_ROWS_INV_EN
      localparam int unsigned InvSrc = (c + NB - OFFSET) % NB;
      aes_byte_t inv_b;

      assign inv_b = row_i[8*NB-1-8*InvSrc -: 8];
      assign row_o[8*NB-1-8*c -: 8] = inv_i ? inv_b : fwd_b;
`else
      assign row_o[8*NB-1-8*c -: 8] = fwd_b;
`endif
   end

`ifndef AES_SHIFT_ROWS_INV_EN
   // Forward-only build: the mode input has no effect.
   logic unused_inv;
   assign unused_inv = inv_i;
`endif

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_pipe
// AES ShiftRows / InvShiftRows with valid/ready handshake, 1-cycle latency and
// a 2-entry (main + skid) output buffer. in_ready is a register, so it never
// depends combinationally on out_ready.
// Configuration macro:
//   AES_SHIFT_ROWS_INV_EN - when defined, in_inv selects InvShiftRows;
//                           otherwise in_inv is ignored (forward only).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - input handshake
//   in_data, in_inv     - state matrix (row-major, row byte 0 = MSB), mode
//   out_valid/out_ready - output handshake
//   out_data            - shifted state matrix
//   blk_cnt             - wrapping count of completed output transfers
// -----------------------------------------------------------------------------
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int unsigned NB    = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_data,
   input  logic              in_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_data,
   output logic [CNT_W-1:0]  blk_cnt
);

   localparam int unsigned W    = 32 * NB;
   localparam int unsigned RowW = 8 * NB;

   if (!nb_legal(NB)) begin : g_nb_illegal
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end

   logic         inv_sel;
   logic [W-1:0] shifted;

`ifdef AES_SHIFT_ROWS_INV_EN
   assign inv_sel = in_inv;
`else
   assign inv_sel = 1'b0;
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
`endif

   for (genvar r = 0; r < NumRows; r++) begin : g_row
      aes_row_rotate #(
         .NB     (NB),
         .OFFSET (row_offset(NB, r))
      ) u_row_rotate (
         .row_i (in_data[W-1-RowW*r -: RowW]),
         .inv_i (inv_sel),
         .row_o (shifted[W-1-RowW*r -: RowW])
      );
   end

   logic [W-1:0]     main_q, main_d;
   logic [W-1:0]     skid_q, skid_d;
   logic             main_vld_q, main_vld_d;
   logic             skid_vld_q, skid_vld_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = main_vld_q & out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      cnt_d      = cnt_q;

      if (out_xfer) begin
         cnt_d = cnt_q + 1'b1;
         // in_ready is low whenever skid is full, so in_xfer cannot coincide here.
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (in_xfer) begin
            main_d = shifted;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (in_xfer) begin
         if (main_vld_q) begin
            skid_d     = shifted;
            skid_vld_d = 1'b1;
         end else begin
            main_d     = shifted;
            main_vld_d = 1'b1;
         end
      end

      in_ready_d = ~skid_vld_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_vld_q;
   assign out_data  = main_q;
   assign blk_cnt   = cnt_q;

endmodule

// File: doc/aes_shift_rows_pipe.md
AES_SHIFT_ROWS_PIPE -- requirements
Module: aes_shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state column count (legal values 4, 6 and 8; block width W = 32*NB).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-block counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  in_data and in_inv are offered.
REQ-006 in_ready  output  1  block will accept an offered word this cycle.
REQ-007 in_data  input  W  state matrix, row-major; row r = in_data[W-1-32*NB*r/4 -: 8*NB]; row byte 0 is its MSB byte.
REQ-008 in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; captured per transfer.
REQ-009 out_valid  output  1  out_data holds a result.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  W  shifted matrix, same layout as in_data.
REQ-012 blk_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-013 Row r SHALL rotate by offset C[r]: NB=4 or 6 → {0,1,2,3}; NB=8 → {0,1,3,4}.
REQ-014 Forward mode SHALL rotate each row left by C[r] bytes (byte 0 takes byte C[r]); inverse mode SHALL rotate right by C[r] bytes.
REQ-015 A transfer SHALL occur on a clk edge where valid && ready; data SHALL be computed combinationally from in_data/in_inv and registered on input transfer.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
REQ-017 Output SHALL be a 2-entry skid buffer (main, skid); in_ready = !skid_full, registered, not combinationally dependent on out_ready.
REQ-018 If the input transfers while main is full and the output does not transfer, the result SHALL go to skid; skid SHALL move to main on the next output transfer.
REQ-019 Simultaneous input and output transfers with main full and skid empty SHALL replace main with no bubble; sustained throughput SHALL be 1 word/cycle.
REQ-020 out_data/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 Output order SHALL equal input order; no word dropped or duplicated.
REQ-022 blk_cnt SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-023 Illegal NB SHALL fail elaboration.

Reset
REQ-024 While rst_n=0 at an edge: out_valid=0, both entries empty, in_ready=0, blk_cnt=0, out_data=0.
REQ-025 in_ready SHALL go to 1 on the first edge with rst_n=1; in-flight words at reset SHALL be discarded.

Configuration
REQ-026 With macro AES_SHIFT_ROWS_INV_EN defined, in_inv SHALL select the inverse per REQ-014.
REQ-027 Without AES_SHIFT_ROWS_INV_EN, in_inv SHALL be ignored, always forward, and no inverse logic synthesised.

Structure
REQ-028 Shared package aes_pkg SHALL hold the NB legality check, the row-offset function C(NB,r) and the byte type.
REQ-029 Sub-module aes_row_rotate (one row, parameters NB and offset, inverse input) SHALL be instantiated 4 times.

Verification
REQ-030 NB=4, fwd, in=0x00010203_10111213_20212223_30313233 -> out=0x00010203_11121310_22232021_33303132 after 1 cycle.
REQ-031 NB=4, inv, in=0x00010203_11121310_22232021_33303132 -> out=0x00010203_10111213_20212223_30313233; without the macro -> forward result.
REQ-032 NB=8, fwd, row2 bytes 0x20..0x27, row3 0x30..0x37 -> row2 0x23242526_27202122, row3 0x34353637_30313233.
REQ-033 Stream 64 random words, out_ready toggled randomly -> in-order match to model, stable hold, no loss, blk_cnt=64.
REQ-034 out_ready=0, in_valid=1 held -> exactly 2 words accepted, then in_ready=0; out_ready=1 -> both drained in order.
REQ-035 Reset asserted with both entries full -> next cycle out_valid=0, blk_cnt=0; CNT_W=4, 17 transfers -> blk_cnt=1.
